// File: rtl/vga_sync_if.sv
// vga_sync_if: timing bundle from the sync generator to the pixel pipe and connector.
interface vga_sync_if;
    logic       pixel_tick;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    modport master (
        output pixel_tick, pixel_x, pixel_y, display_on,
        output hsync, vsync, line_start, frame_start
    );
    modport slave (
        input pixel_tick, pixel_x, pixel_y, display_on,
        input hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with pixel-rate enable, raw x/y counters and registered decodes
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit SYNC_POL  = 1'b0
) (
    input logic        clock_50,
    input logic        reset,
    vga_sync_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO   = H_VISIBLE + H_FRONT;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_VISIBLE + V_FRONT;
    localparam int VS_HI   = VS_LO + V_SYNC;
    localparam int DW      = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [DW-1:0] div_cnt, div_nxt;
    logic [9:0]    x, y, x_nxt, y_nxt;
    logic          adv, x_wrap, y_wrap, hs_on, vs_on;
    logic          tick, don, hs, vs, ls, fs;
    always_comb begin
        adv     = div_cnt == DW'(CLK_DIV - 1);
        x_wrap  = x == 10'(H_TOTAL - 1);
        y_wrap  = y == 10'(V_TOTAL - 1);
        div_nxt = adv ? '0 : div_cnt + DW'(1);
        x_nxt   = adv ? (x_wrap ? '0 : x + 10'd1) : x;
        y_nxt   = (adv && x_wrap) ? (y_wrap ? '0 : y + 10'd1) : y;
        hs_on   = x_nxt >= 10'(HS_LO) && x_nxt < 10'(HS_HI);
        vs_on   = y_nxt >= 10'(VS_LO) && y_nxt < 10'(VS_HI);
    end
    // decodes use next-state counters so they line up with x/y in the same cycle
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            x       <= '0;
            y       <= '0;
            tick    <= 1'b0;
            don     <= 1'b0;
            hs      <= ~SYNC_POL;
            vs      <= ~SYNC_POL;
            ls      <= 1'b0;
            fs      <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            tick    <= adv;
            don     <= x_nxt < 10'(H_VISIBLE) && y_nxt < 10'(V_VISIBLE);
            hs      <= hs_on ? SYNC_POL : ~SYNC_POL;
            vs      <= vs_on ? SYNC_POL : ~SYNC_POL;
            ls      <= adv && x_wrap;
            fs      <= adv && x_wrap && y_wrap;
        end
    end
    assign vga.pixel_tick  = tick;
    assign vga.pixel_x     = x;
    assign vga.pixel_y     = y;
    assign vga.display_on  = don;
    assign vga.hsync       = hs;
    assign vga.vsync       = vs;
    assign vga.line_start  = ls;
    assign vga.frame_start = fs;
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench; full 640x480 timing for reset/line checks, shrunk timings for frame and CLK_DIV=1.
module tb_vga_sync_gen;
    typedef struct packed {
        logic       tick;
        logic [9:0] x;
        logic [9:0] y;
        logic       don;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
    } smp_t;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int n_chk = 0, n_fail = 0;
    int ka = 0, kb = 0, kc = 0;
    smp_t qa[$], qb[$], qc[$];
    always #5 clk = ~clk;
    vga_sync_if ia();
    vga_sync_if ib();
    vga_sync_if ic();
    vga_sync_gen dut_a (.clock_50(clk), .reset(rst_a), .vga(ia));
    vga_sync_gen #(.CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1))
        dut_b (.clock_50(clk), .reset(rst_b), .vga(ib));
    vga_sync_gen #(.CLK_DIV(3), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                   .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0))
        dut_c (.clock_50(clk), .reset(rst_c), .vga(ic));
    // k = rising edges since reset release; pixel index advances once every d edges
    function automatic smp_t model(int k, int d, int h_vis, int h_fp, int h_sw, int h_bp,
                                   int v_vis, int v_fp, int v_sw, int v_bp, bit pol);
        smp_t r;
        int ht, vt, n, px, py;
        ht = h_vis + h_fp + h_sw + h_bp;
        vt = v_vis + v_fp + v_sw + v_bp;
        r = '0;
        r.hs = ~pol;
        r.vs = ~pol;
        if (k > 0) begin
            n = k / d;
            px = n % ht;
            py = (n / ht) % vt;
            r.tick = (k % d) == 0;
            r.x = 10'(px);
            r.y = 10'(py);
            r.don = px < h_vis && py < v_vis;
            r.hs = (px >= h_vis + h_fp && px < h_vis + h_fp + h_sw) ? pol : ~pol;
            r.vs = (py >= v_vis + v_fp && py < v_vis + v_fp + v_sw) ? pol : ~pol;
            r.ls = r.tick && px == 0 && n > 0;
            r.fs = r.ls && py == 0;
        end
        return r;
    endfunction
    function automatic smp_t exp_a(int k); return model(k, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0); endfunction
    function automatic smp_t exp_b(int k); return model(k, 1, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1); endfunction
    function automatic smp_t exp_c(int k); return model(k, 3, 8, 2, 3, 2, 4, 1, 2, 1, 1'b0); endfunction
    function automatic smp_t obs_a();
        return {ia.pixel_tick, ia.pixel_x, ia.pixel_y, ia.display_on, ia.hsync, ia.vsync, ia.line_start, ia.frame_start};
    endfunction
    function automatic smp_t obs_b();
        return {ib.pixel_tick, ib.pixel_x, ib.pixel_y, ib.display_on, ib.hsync, ib.vsync, ib.line_start, ib.frame_start};
    endfunction
    function automatic smp_t obs_c();
        return {ic.pixel_tick, ic.pixel_x, ic.pixel_y, ic.display_on, ic.hsync, ic.vsync, ic.line_start, ic.frame_start};
    endfunction
    task automatic step_a(); @(posedge clk); ka++; qa.push_back(exp_a(ka)); @(negedge clk); endtask
    task automatic step_b(); @(posedge clk); kb++; qb.push_back(exp_b(kb)); @(negedge clk); endtask
    task automatic step_c(); @(posedge clk); kc++; qc.push_back(exp_c(kc)); @(negedge clk); endtask
    task automatic test_reset();
        smp_t e, o;
        rst_a = 1'b1;
        ka = 0;
        repeat (5) begin
            @(negedge clk);
            qa.push_back(exp_a(0));
            e = qa.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL reset_hold got=%p exp=%p", o, e); end
        end
        rst_a = 1'b0;
        step_a();
        e = qa.pop_front(); o = obs_a(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL first_edge got=%p exp=%p", o, e); end
        n_chk++;
        if (o.don !== 1'b1) begin n_fail++; $display("FAIL first_display_on got=%b exp=1", o.don); end
    endtask
    task automatic test_tick();
        smp_t e, o;
        int ticks = 0;
        repeat (20) begin
            step_a();
            e = qa.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL tick_run k=%0d got=%p exp=%p", ka, o, e); end
            if (o.tick) ticks++;
        end
        n_chk++;
        if (ticks !== 10) begin n_fail++; $display("FAIL tick_count got=%0d exp=10", ticks); end
    endtask
    task automatic test_line();
        smp_t e, o;
        int hlow = 0, nls = 0, fall_x = -1;
        logic prev = ia.display_on;
        while (ka < 1610) begin
            step_a();
            e = qa.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL line k=%0d got=%p exp=%p", ka, o, e); end
            if (!o.hs) hlow++;
            if (o.ls) nls++;
            if (prev && !o.don) fall_x = int'(o.x);
            prev = o.don;
        end
        n_chk++;
        if (hlow !== 192) begin n_fail++; $display("FAIL hsync_width got=%0d exp=192 clocks", hlow); end
        n_chk++;
        if (nls !== 1) begin n_fail++; $display("FAIL line_start_count got=%0d exp=1", nls); end
        n_chk++;
        if (fall_x !== 640) begin n_fail++; $display("FAIL display_off_x got=%0d exp=640", fall_x); end
    endtask
    task automatic test_async_reset();
        smp_t e, o;
        while (ka < 2200) begin
            step_a();
            e = qa.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL pre_reset k=%0d got=%p exp=%p", ka, o, e); end
        end
        #2 rst_a = 1'b1;
        #1;
        qa.push_back(exp_a(0));
        e = qa.pop_front(); o = obs_a(); n_chk++;
        if (o !== e) begin n_fail++; $display("FAIL async_reset got=%p exp=%p", o, e); end
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        ka = 0;
        repeat (4) begin
            step_a();
            e = qa.pop_front(); o = obs_a(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL restart k=%0d got=%p exp=%p", ka, o, e); end
        end
    endtask
    task automatic test_frame();
        smp_t e, o;
        int nfs = 0, vlow = 0;
        rst_c = 1'b1;
        repeat (2) @(negedge clk);
        rst_c = 1'b0;
        kc = 0;
        while (kc < 730) begin
            step_c();
            e = qc.pop_front(); o = obs_c(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL frame k=%0d got=%p exp=%p", kc, o, e); end
            if (o.fs) nfs++;
            if (!o.vs) vlow++;
        end
        n_chk++;
        if (nfs !== 2) begin n_fail++; $display("FAIL frame_start_count got=%0d exp=2", nfs); end
        n_chk++;
        if (vlow !== 180) begin n_fail++; $display("FAIL vsync_width got=%0d exp=180 clocks", vlow); end
    endtask
    task automatic test_div1();
        smp_t e, o;
        int ticks = 0, hhigh = 0, vhigh = 0;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        kb = 0;
        repeat (250) begin
            step_b();
            e = qb.pop_front(); o = obs_b(); n_chk++;
            if (o !== e) begin n_fail++; $display("FAIL div1 k=%0d got=%p exp=%p", kb, o, e); end
            if (o.tick) ticks++;
            if (o.hs) hhigh++;
            if (o.vs) vhigh++;
        end
        n_chk++;
        if (ticks !== 250) begin n_fail++; $display("FAIL div1_ticks got=%0d exp=250", ticks); end
        n_chk++;
        if (hhigh !== 49) begin n_fail++; $display("FAIL div1_hsync_high got=%0d exp=49", hhigh); end
        n_chk++;
        if (vhigh !== 60) begin n_fail++; $display("FAIL div1_vsync_high got=%0d exp=60", vhigh); end
    endtask
    initial begin
        test_reset();
        test_tick();
        test_line();
        test_async_reset();
        test_frame();
        test_div1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
